profiler_readout: RTL and testbench
===================================

Name: profiler_readout

Overview:
- Memory-mapped responder on the Aquila device bus that makes the cache profiler's event and latency counters readable by software.
- The profiler accumulates the counters; this block freezes a consistent copy of them on command and serves that copy as 32-bit words.
- It also issues a one-cycle clear pulse back to the profiler.
- Sits beside the D-cache profiler; selected by the top-level address decoder.

Parameters:
XLEN, 32, CPU data/address width
N_CNT, 7, number of event counters (write_hit, write_miss, write_dirty, read_hit, read_miss, read_dirty, flush)
N_LAT, 8, number of latency accumulators (wm, wmd, rm, rmd, flush, hit, hit_r, hit_w)
LAT_W, XLEN+8, width of each latency accumulator

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
cnt_i  in  N_CNT*XLEN  live event counters, packed, counter k at [k*XLEN +: XLEN]
lat_i  in  N_LAT*LAT_W  live latency accumulators, packed, same ordering rule
strobe_i  in  1  one-cycle bus request
rw_i  in  1  1=write, 0=read
addr_i  in  8  byte offset within the block; bits [1:0] ignored
data_i  in  XLEN  write data
data_o  out  XLEN  read data, valid while ready_o=1
ready_o  out  1  one-cycle response strobe
clr_o  out  1  one-cycle clear request to the profiler

Behaviour:
- Reset (rst_ni low, asynchronous):
  - ready_o=0, data_o=0, clr_o=0.
  - All snapshot registers 0; snap_valid=0, seq=0, err=0.
  - FSM goes to IDLE; any in-flight request is dropped with no ready_o.
- FSM states:
  - IDLE: on strobe_i, latch rw_i/addr_i/data_i. A write to CTRL with data_i[0]=1 goes to SNAP; every other access goes to RESP.
  - SNAP: one cycle. Copy cnt_i and lat_i into the snapshot registers, set snap_valid=1, seq<=seq+1. Then go to RESP.
  - RESP: ready_o=1 for exactly one cycle with data_o driven, then return to IDLE. data_o returns to 0 after the response.
- Latency: strobe at cycle T gives ready_o at T+1; a snapshot write gives ready_o at T+2.
- strobe_i is ignored in SNAP and RESP; the master must wait for ready_o before the next request.
- Register map (word offsets):
  - 0x00 CTRL: write bit0=snapshot, bit1=clear; reads return 0.
  - 0x04 STATUS (read-only): bit0 snap_valid, bit1 err (sticky), [15:8] seq. A write with data_i[1]=1 clears err.
  - 0x10+4k, k=0..6: counter k snapshot.
  - 0x40+8j: latency j bits [31:0].
  - 0x44+8j: latency j bits [LAT_W-1:32], zero-extended.
- Reads always return snapshot values, never the live inputs, so a lo/hi pair is always consistent.
- Clear:
  - A CTRL write with bit1=1 pulses clr_o for 1 cycle, in the cycle ready_o is asserted.
  - If bit0 and bit1 are set together: SNAP captures the pre-clear values, then clr_o pulses in RESP.
  - Clear does not alter the snapshot registers or snap_valid.
- Unmapped offsets: reads return 0, writes are ignored; ready_o is still asserted and err is set. Writes to read-only registers are ignored silently (err not set).
- seq wraps 0xFF -> 0x00. There is no counter arithmetic other than seq; input widths pass through unchanged.

Decomposition:
- Shared package/header (prof_pkg / aquila_config.vh): register offsets, CTRL bit indices, counter and latency index constants, FSM state encodings.
- One natural sub-module, prof_snapshot_bank: the capture registers plus the word-select read mux. The FSM and decode stay in profiler_readout.

Test Plan:
- Reset, then read STATUS at 0x04 -> ready_o at T+1, data_o=0x00000000.
- cnt_i counter 3 = 0x00000123, CTRL write 0x1 -> ready_o at T+2. Read 0x1C -> 0x123. Read STATUS -> 0x00000101.
- lat_i latency 5 = 0xAB_DEADBEEF, snapshot, then change lat_i -> 0x68 reads 0xDEADBEEF, 0x6C reads 0x000000AB.
- CTRL write 0x3 with counter 0 = 7 -> snapshot holds 7; clr_o high exactly in the ready_o cycle; seq increments.
- Read 0xF0 -> data_o=0, ready_o=1, STATUS bit1=1. STATUS write 0x2 -> bit1=0.
- Deassert rst_ni during SNAP -> no ready_o, snap_valid=0, seq=0. Perform 256 snapshots -> seq wraps to 0x00.

Source files
------------

// File: rtl/profiler_readout_pkg.sv
// Shared definitions for the cache profiler readout block: bus/counter
// geometry, register word offsets, CTRL/STATUS bit positions, FSM states
// and the address-map decode helper.
package profiler_readout_pkg;

  localparam int XLEN  = 32;
  localparam int N_CNT = 7;
  localparam int N_LAT = 8;
  localparam int LAT_W = XLEN + 8;

  // Event counter indices
  localparam int CNT_WRITE_HIT   = 0;
  localparam int CNT_WRITE_MISS  = 1;
  localparam int CNT_WRITE_DIRTY = 2;
  localparam int CNT_READ_HIT    = 3;
  localparam int CNT_READ_MISS   = 4;
  localparam int CNT_READ_DIRTY  = 5;
  localparam int CNT_FLUSH       = 6;

  // Latency accumulator indices
  localparam int LAT_WM    = 0;
  localparam int LAT_WMD   = 1;
  localparam int LAT_RM    = 2;
  localparam int LAT_RMD   = 3;
  localparam int LAT_FLUSH = 4;
  localparam int LAT_HIT   = 5;
  localparam int LAT_HIT_R = 6;
  localparam int LAT_HIT_W = 7;

  // Register map in 32-bit word units (byte offset >> 2)
  localparam logic [5:0] CTRL_W     = 6'd0;   // 0x00
  localparam logic [5:0] STATUS_W   = 6'd1;   // 0x04
  localparam logic [5:0] CNT_BASE_W = 6'd4;   // 0x10
  localparam logic [5:0] CNT_END_W  = 6'd11;  // first word past the counters
  localparam logic [5:0] LAT_BASE_W = 6'd16;  // 0x40
  localparam logic [5:0] LAT_END_W  = 6'd32;  // first word past the latencies

  // CTRL / STATUS bit positions
  localparam int CTRL_SNAP_BIT  = 0;
  localparam int CTRL_CLR_BIT   = 1;
  localparam int STATUS_ERR_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SNAP = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // True for every word offset that has a register behind it.
  function automatic logic addr_mapped(input logic [5:0] w);
    return (w == CTRL_W) || (w == STATUS_W) ||
           ((w >= CNT_BASE_W) && (w < CNT_END_W)) ||
           ((w >= LAT_BASE_W) && (w < LAT_END_W));
  endfunction

endpackage

// File: rtl/profiler_readout_snapshot_bank.sv
// Snapshot bank: frozen copies of the event counters and latency
// accumulators plus the word-select read mux over them.
// Ports: clk_i/rst_ni clock and async active-low reset; capture copies
// cnt_i/lat_i into the bank; word selects a 32-bit word; rdata is the
// selected snapshot word (0 for words outside the counter/latency ranges).
module profiler_readout_snapshot_bank
  import profiler_readout_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   capture,
  input  logic [N_CNT*XLEN-1:0]  cnt_i,
  input  logic [N_LAT*LAT_W-1:0] lat_i,
  input  logic [5:0]             word,
  output logic [XLEN-1:0]        rdata
);

  logic [N_CNT*XLEN-1:0]  cnt_snap;
  logic [N_LAT*LAT_W-1:0] lat_snap;

  // Capture registers: loaded only on capture, otherwise hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_snap <= '0;
      lat_snap <= '0;
    end else if (capture) begin
      cnt_snap <= cnt_i;
      lat_snap <= lat_i;
    end else begin
      cnt_snap <= cnt_snap;
      lat_snap <= lat_snap;
    end
  end

  // Read mux: each latency occupies a lo word then a zero-extended hi word.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < N_CNT; k++) begin
      rdata = (word == 6'(CNT_BASE_W + 6'(k))) ? cnt_snap[k*XLEN +: XLEN] : rdata;
    end
    for (int j = 0; j < N_LAT; j++) begin
      rdata = (word == 6'(LAT_BASE_W + 6'(2*j))) ?
              lat_snap[j*LAT_W +: XLEN] : rdata;
      rdata = (word == 6'(LAT_BASE_W + 6'(2*j + 1))) ?
              XLEN'(lat_snap[j*LAT_W+XLEN +: LAT_W-XLEN]) : rdata;
    end
  end

endmodule

// File: rtl/profiler_readout.sv
// Cache profiler readout: bus responder that freezes the profiler counters
// on command and serves the frozen copy as 32-bit words.
// Ports: clk_i/rst_ni clock and async active-low reset; cnt_i/lat_i live
// profiler values; strobe_i/rw_i/addr_i/data_i one-cycle bus request;
// data_o/ready_o one-cycle registered response; clr_o one-cycle clear
// pulse to the profiler, coincident with ready_o.
module profiler_readout
  import profiler_readout_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_CNT*XLEN-1:0]  cnt_i,
  input  logic [N_LAT*LAT_W-1:0] lat_i,
  input  logic                   strobe_i,
  input  logic                   rw_i,
  input  logic [7:0]             addr_i,
  input  logic [XLEN-1:0]        data_i,
  output logic [XLEN-1:0]        data_o,
  output logic                   ready_o,
  output logic                   clr_o
);

  state_t          state;
  logic            req_clr;
  logic            snap_valid;
  logic            err;
  logic [7:0]      seq;
  logic [5:0]      word;
  logic [XLEN-1:0] bank_rdata;
  logic [XLEN-1:0] rd_data;
  logic            capture;
  logic            unused_bits;

  assign word        = addr_i[7:2];
  assign capture     = (state == ST_SNAP);
  assign unused_bits = ^{addr_i[1:0], data_i[XLEN-1:2]};

  profiler_readout_snapshot_bank u_bank (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .capture (capture),
    .cnt_i   (cnt_i),
    .lat_i   (lat_i),
    .word    (word),
    .rdata   (bank_rdata)
  );

  // Read data for the current request; STATUS is the only live register.
  always_comb begin
    rd_data = bank_rdata;
    if (word == STATUS_W) begin
      rd_data = {16'h0000, seq, 6'b000000, err, snap_valid};
    end else begin
      rd_data = bank_rdata;
    end
  end

  // Request FSM with registered response outputs. ready_o is raised on the
  // edge that enters RESP, so RESP is exactly the response cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      req_clr    <= 1'b0;
      snap_valid <= 1'b0;
      err        <= 1'b0;
      seq        <= 8'h00;
      ready_o    <= 1'b0;
      data_o     <= '0;
      clr_o      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ready_o <= 1'b0;
          data_o  <= '0;
          clr_o   <= 1'b0;
          if (strobe_i) begin
            if (rw_i && (word == CTRL_W) && data_i[CTRL_SNAP_BIT]) begin
              // Capture first; any clear waits for the response cycle.
              req_clr <= data_i[CTRL_CLR_BIT];
              state   <= ST_SNAP;
            end else begin
              ready_o <= 1'b1;
              state   <= ST_RESP;
              if (rw_i) begin
                clr_o <= (word == CTRL_W) && data_i[CTRL_CLR_BIT];
                if (!addr_mapped(word)) begin
                  err <= 1'b1;
                end else if ((word == STATUS_W) && data_i[STATUS_ERR_BIT]) begin
                  err <= 1'b0;
                end else begin
                  err <= err;
                end
              end else begin
                data_o <= rd_data;
                if (!addr_mapped(word)) begin
                  err <= 1'b1;
                end else begin
                  err <= err;
                end
              end
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SNAP: begin
          snap_valid <= 1'b1;
          seq        <= seq + 8'd1;
          ready_o    <= 1'b1;
          data_o     <= '0;
          clr_o      <= req_clr;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          ready_o <= 1'b0;
          data_o  <= '0;
          clr_o   <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          ready_o <= 1'b0;
          data_o  <= '0;
          clr_o   <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_profiler_readout.sv
// Self-checking bench for profiler_readout: a table of directed bus
// accesses with hand-computed responses, then hand-written sequences for
// snapshot consistency, snapshot+clear, reset during SNAP and seq wrap.
module tb_profiler_readout;
  import profiler_readout_pkg::*;

  logic                   clk_i;
  logic                   rst_ni;
  logic [N_CNT*XLEN-1:0]  cnt_i;
  logic [N_LAT*LAT_W-1:0] lat_i;
  logic                   strobe_i;
  logic                   rw_i;
  logic [7:0]             addr_i;
  logic [XLEN-1:0]        data_i;
  logic [XLEN-1:0]        data_o;
  logic                   ready_o;
  logic                   clr_o;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
    logic        exp_clr;
  } vec_t;

  vec_t vecs[$];

  profiler_readout dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .cnt_i    (cnt_i),
    .lat_i    (lat_i),
    .strobe_i (strobe_i),
    .rw_i     (rw_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .data_o   (data_o),
    .ready_o  (ready_o),
    .clr_o    (clr_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // One bus access: drive at a falling edge, wait (bounded) for ready_o,
  // check data, latency, clear pulse and the idle cycle after the response.
  task automatic access(input string name, input logic rw, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data,
                        input int exp_lat, input logic exp_clr);
    int          lat;
    int          clr_cnt;
    logic        clr_at_ready;
    logic [31:0] got;
    logic        done;
    lat = 0; clr_cnt = 0; clr_at_ready = 1'b0; got = 32'h0; done = 1'b0;
    @(negedge clk_i);
    strobe_i = 1'b1; rw_i = rw; addr_i = addr; data_i = wdata;
    while (!done && lat < 20) begin
      @(negedge clk_i);
      strobe_i = 1'b0;
      lat++;
      if (clr_o) clr_cnt++;
      if (ready_o) begin
        got = data_o;
        clr_at_ready = clr_o;
        done = 1'b1;
      end
    end
    if (!done) lat = -1;
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " data"}, got, exp_data);
    check({name, " clr_at_ready"}, {31'h0, clr_at_ready}, {31'h0, exp_clr});
    @(negedge clk_i);
    if (clr_o) clr_cnt++;
    check({name, " clr_pulses"}, 32'(clr_cnt), {31'h0, exp_clr});
    check({name, " idle_after"}, {30'h0, ready_o, |data_o}, 32'h0);
  endtask

  task automatic snapshot_only();
    access("snap", 1'b1, 8'h00, 32'h1, 32'h0, 2, 1'b0);
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    strobe_i = 1'b0; rw_i = 1'b0; addr_i = 8'h00; data_i = 32'h0;
    for (int k = 0; k < N_CNT; k++) cnt_i[k*XLEN +: XLEN] = 32'h120 + 32'(k);
    for (int j = 0; j < N_LAT; j++)
      lat_i[j*LAT_W +: LAT_W] = {8'hA0 + 8'(j), 32'hDEAD0000 + 32'(j)};

    // Reset state
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset outputs", {30'h0, ready_o, clr_o} | data_o, 32'h0);
    rst_ni = 1'b1;

    vecs.push_back('{1'b0, 8'h04, 32'h0,    32'h0,        1, 1'b0});
    vecs.push_back('{1'b0, 8'h1C, 32'h0,    32'h0,        1, 1'b0});
    vecs.push_back('{1'b1, 8'h00, 32'h1,    32'h0,        2, 1'b0});
    vecs.push_back('{1'b0, 8'h1C, 32'h0,    32'h123,      1, 1'b0});
    vecs.push_back('{1'b0, 8'h04, 32'h0,    32'h101,      1, 1'b0});
    vecs.push_back('{1'b0, 8'h10, 32'h0,    32'h120,      1, 1'b0});
    vecs.push_back('{1'b0, 8'h28, 32'h0,    32'h126,      1, 1'b0});
    vecs.push_back('{1'b0, 8'h40, 32'h0,    32'hDEAD0000, 1, 1'b0});
    vecs.push_back('{1'b0, 8'h44, 32'h0,    32'hA0,       1, 1'b0});
    vecs.push_back('{1'b0, 8'h78, 32'h0,    32'hDEAD0007, 1, 1'b0});
    vecs.push_back('{1'b0, 8'h7C, 32'h0,    32'hA7,       1, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 32'h0,    32'h0,        1, 1'b0});
    vecs.push_back('{1'b1, 8'h10, 32'hFFFF, 32'h0,        1, 1'b0});
    vecs.push_back('{1'b0, 8'h04, 32'h0,    32'h101,      1, 1'b0});
    vecs.push_back('{1'b0, 8'h1E, 32'h0,    32'h123,      1, 1'b0});
    vecs.push_back('{1'b0, 8'h2C, 32'h0,    32'h0,        1, 1'b0});
    vecs.push_back('{1'b0, 8'h04, 32'h0,    32'h103,      1, 1'b0});
    vecs.push_back('{1'b1, 8'h04, 32'h2,    32'h0,        1, 1'b0});
    vecs.push_back('{1'b0, 8'h04, 32'h0,    32'h101,      1, 1'b0});
    vecs.push_back('{1'b1, 8'h80, 32'h5,    32'h0,        1, 1'b0});
    vecs.push_back('{1'b0, 8'h04, 32'h0,    32'h103,      1, 1'b0});
    vecs.push_back('{1'b1, 8'h04, 32'h2,    32'h0,        1, 1'b0});
    vecs.push_back('{1'b0, 8'hF0, 32'h0,    32'h0,        1, 1'b0});
    vecs.push_back('{1'b0, 8'h04, 32'h0,    32'h103,      1, 1'b0});
    vecs.push_back('{1'b1, 8'h04, 32'h2,    32'h0,        1, 1'b0});
    vecs.push_back('{1'b1, 8'h00, 32'h2,    32'h0,        1, 1'b1});
    vecs.push_back('{1'b0, 8'h04, 32'h0,    32'h101,      1, 1'b0});
    vecs.push_back('{1'b0, 8'h1C, 32'h0,    32'h123,      1, 1'b0});

    foreach (vecs[i])
      access($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_data, vecs[i].exp_lat, vecs[i].exp_clr);

    // Lo/hi pair comes from the snapshot even after the live value moves.
    lat_i[LAT_HIT*LAT_W +: LAT_W] = 40'hAB_DEADBEEF;
    snapshot_only();
    lat_i[LAT_HIT*LAT_W +: LAT_W] = 40'h11_22334455;
    access("lat5 lo", 1'b0, 8'h68, 32'h0, 32'hDEADBEEF, 1, 1'b0);
    access("lat5 hi", 1'b0, 8'h6C, 32'h0, 32'h000000AB, 1, 1'b0);
    access("status seq2", 1'b0, 8'h04, 32'h0, 32'h201, 1, 1'b0);

    // Snapshot + clear together: pre-clear value captured, clr in ready cycle.
    cnt_i[CNT_WRITE_HIT*XLEN +: XLEN] = 32'h7;
    access("snap+clr", 1'b1, 8'h00, 32'h3, 32'h0, 2, 1'b1);
    access("cnt0 after clr", 1'b0, 8'h10, 32'h0, 32'h7, 1, 1'b0);
    access("status seq3", 1'b0, 8'h04, 32'h0, 32'h301, 1, 1'b0);

    // Reset while in SNAP: the request is dropped without a response.
    @(negedge clk_i);
    strobe_i = 1'b1; rw_i = 1'b1; addr_i = 8'h00; data_i = 32'h1;
    @(negedge clk_i);
    strobe_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("rst in snap outputs", {30'h0, ready_o, clr_o} | data_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    begin
      int ready_seen;
      ready_seen = 0;
      repeat (4) begin
        @(negedge clk_i);
        if (ready_o) ready_seen++;
      end
      check("no ready after rst", 32'(ready_seen), 32'h0);
    end
    access("status after rst", 1'b0, 8'h04, 32'h0, 32'h0, 1, 1'b0);
    access("cnt3 after rst", 1'b0, 8'h1C, 32'h0, 32'h0, 1, 1'b0);

    // 256 snapshots wrap seq back to zero.
    for (int n = 0; n < 255; n++) snapshot_only();
    access("status seq ff", 1'b0, 8'h04, 32'h0, 32'h0000FF01, 1, 1'b0);
    snapshot_only();
    access("status seq wrap", 1'b0, 8'h04, 32'h0, 32'h00000001, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
